// File: rtl/bin_to_hexa_if.sv
// Nibble-in / display-views-out bundle for the hex digit converter.
// The producer drives en/x; the converter returns the three registered views.
interface bin_to_hexa_if;
  logic        en;
  logic [3:0]  x;
  logic [15:0] y;
  logic [6:0]  seg;
  logic [7:0]  ascii;
  logic        valid;

  modport master (output en, x, input y, seg, ascii, valid);
  modport slave  (input en, x, output y, seg, ascii, valid);
endinterface

// File: rtl/bin_to_hexa.sv
// Registered 4-bit to hex-digit converter: one-hot decode, seven-segment glyph and
// ASCII character, all appearing one cycle after a capture strobe.
module bin_to_hexa #(
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit UPPERCASE      = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  bin_to_hexa_if.slave  bus
);

  // The "off" glyph follows the polarity so a reset display is dark either way.
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  function automatic logic [6:0] seg_glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return SEG_ACTIVE_LOW ? ~g : g;
  endfunction

  function automatic logic [7:0] ascii_char(input logic [3:0] n);
    logic [7:0] base;
    if (n < 4'd10) begin
      return 8'h30 + {4'h0, n};
    end
    base = UPPERCASE ? 8'h41 : 8'h61;
    return base + {4'h0, n} - 8'd10;
  endfunction

  logic [15:0] y_d, y_q;
  logic [6:0]  seg_d, seg_q;
  logic [7:0]  ascii_d, ascii_q;
  logic        valid_d, valid_q;

  always_comb begin
    y_d     = y_q;
    seg_d   = seg_q;
    ascii_d = ascii_q;
    valid_d = 1'b0;
    if (bus.en) begin
      y_d     = 16'd1 << bus.x;
      seg_d   = seg_glyph(bus.x);
      ascii_d = ascii_char(bus.x);
      valid_d = 1'b1;
    end
  end

  // Output register stage: reset wins over a same-cycle capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q     <= 16'h0000;
      seg_q   <= SEG_OFF;
      ascii_q <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      seg_q   <= seg_d;
      ascii_q <= ascii_d;
      valid_q <= valid_d;
    end
  end

  assign bus.y     = y_q;
  assign bus.seg   = seg_q;
  assign bus.ascii = ascii_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_bin_to_hexa.sv
// Scoreboard bench: two converter instances (default and active-low/lowercase)
// driven in lockstep, expected views queued per cycle and checked by a monitor.
module tb_bin_to_hexa;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bin_to_hexa_if ifa ();
  bin_to_hexa_if ifb ();

  bin_to_hexa dut_a (.clk(clk), .rst(rst), .bus(ifa));
  bin_to_hexa #(.SEG_ACTIVE_LOW(1'b1), .UPPERCASE(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  typedef struct {
    logic [15:0] y;
    logic [6:0]  seg_a;
    logic [6:0]  seg_b;
    logic [7:0]  asc_a;
    logic [7:0]  asc_b;
    logic        valid;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference state: what the display should be showing right now.
  exp_t cur;
  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  string hex_up = "0123456789ABCDEF";
  string hex_lo = "0123456789abcdef";

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // One stimulus cycle: set inputs, advance the model, queue the expected result.
  task automatic cyc(input logic r, input logic e, input logic [3:0] v, input string tag);
    rst   = r;
    ifa.en = e; ifa.x = v;
    ifb.en = e; ifb.x = v;
    if (r) begin
      cur.y = 16'h0; cur.seg_a = 7'h00; cur.seg_b = 7'h7F;
      cur.asc_a = 8'h00; cur.asc_b = 8'h00; cur.valid = 1'b0;
    end else if (e) begin
      cur.y     = 16'h0;
      cur.y[v]  = 1'b1;
      cur.seg_a = glyph[v];
      cur.seg_b = ~glyph[v];
      cur.asc_a = hex_up[v];
      cur.asc_b = hex_lo[v];
      cur.valid = 1'b1;
    end else begin
      cur.valid = 1'b0;
    end
    cur.tag = tag;
    exp_q.push_back(cur);
    @(posedge clk);
    #1;
  endtask

  // Monitor: the registered outputs are presented every cycle; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.tag, " y"},       {16'h0, ifa.y},     {16'h0, e.y});
        chk({e.tag, " seg"},     {25'h0, ifa.seg},   {25'h0, e.seg_a});
        chk({e.tag, " ascii"},   {24'h0, ifa.ascii}, {24'h0, e.asc_a});
        chk({e.tag, " valid"},   {31'h0, ifa.valid}, {31'h0, e.valid});
        chk({e.tag, " y_b"},     {16'h0, ifb.y},     {16'h0, e.y});
        chk({e.tag, " seg_b"},   {25'h0, ifb.seg},   {25'h0, e.seg_b});
        chk({e.tag, " ascii_b"}, {24'h0, ifb.ascii}, {24'h0, e.asc_b});
        chk({e.tag, " valid_b"}, {31'h0, ifb.valid}, {31'h0, e.valid});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cur = '{16'h0, 7'h00, 7'h7F, 8'h00, 8'h00, 1'b0, "init"};

    cyc(1, 1, 4'h5, "reset1");
    cyc(1, 1, 4'h5, "reset2");
    cyc(0, 0, 4'h5, "post_reset");
    cyc(0, 0, 4'hA, "post_reset2");

    for (int i = 0; i < 16; i++) cyc(0, 1, i[3:0], $sformatf("sweep%0h", i));

    cyc(0, 1, 4'h9, "cap9");
    cyc(0, 0, 4'h3, "hold3");
    cyc(0, 0, 4'hC, "holdC");

    cyc(0, 1, 4'h7, "stream7a");
    cyc(0, 1, 4'h7, "stream7b");
    cyc(1, 1, 4'hB, "rst_midB");
    cyc(0, 0, 4'hB, "after_rst");

    cyc(0, 1, 4'hD, "capD");
    cyc(0, 0, 4'h0, "holdD");

    cyc(0, 1, 4'h2, "pulse2");
    cyc(0, 0, 4'h6, "after_pulse1");
    cyc(0, 0, 4'h1, "after_pulse2");

    for (int i = 0; i < 300; i++) begin
      logic r, e;
      r = ($urandom_range(0, 19) == 0);
      e = ($urandom_range(0, 3) != 0);
      cyc(r, e, 4'($urandom_range(0, 15)), $sformatf("rand%0d", i));
    end

    cyc(0, 0, 4'h0, "drain");
    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
